// File: rtl/gcd_stream.sv
// gcd_stream: binary (Stein) GCD engine with valid/ready handshakes on both sides.
// Each job is accepted only while idle. The result and its latency are held
// until the consumer takes them.
module gcd_stream #(
  parameter int BYTES = 2,
  parameter int CW    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*BYTES-1:0]   a,
  input  logic [8*BYTES-1:0]   b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*BYTES-1:0]   o,
  output logic [CW-1:0]        cycles
);

  localparam int W  = 8 * BYTES;
  localparam int KW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STRIP,
    S_REDUCE,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nx;

  logic [W-1:0]    ra;
  logic [W-1:0]    rb;
  logic [KW-1:0]   k;
  logic [W-1:0]    res;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            zero_op;
  logic            both_even;
  logic            odd_equal;

  // Latency counter stops at all-ones instead of wrapping
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && in_ready;
  assign zero_op   = (a == '0) || (b == '0);
  assign both_even = !ra[0] && !rb[0];
  assign odd_equal = ra[0] && rb[0] && (ra == rb);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: strip common twos, reduce odd pair, shift back, then hold
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nx = zero_op ? S_DONE : S_STRIP;
        end
      end
      S_STRIP: begin
        if (!both_even) begin
          state_nx = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (odd_equal) begin
          state_nx = S_FIXUP;
        end
      end
      S_FIXUP: begin
        state_nx = S_DONE;
      end
      S_DONE: begin
        if (out_valid && out_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Working registers: one Stein step per cycle, latency counted until DONE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra  <= '0;
      rb  <= '0;
      k   <= '0;
      res <= '0;
      cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            ra  <= a;
            rb  <= b;
            k   <= '0;
            cnt <= {{(CW-1){1'b0}}, 1'b1};
            // Zero-operand jobs finish here: gcd(x,0)=x, gcd(0,0)=0
            res <= a | b;
          end
        end
        S_STRIP: begin
          cnt <= sat_inc(cnt);
          if (both_even) begin
            ra <= ra >> 1;
            rb <= rb >> 1;
            k  <= k + 1'b1;
          end
        end
        S_REDUCE: begin
          cnt <= sat_inc(cnt);
          if (!ra[0]) begin
            ra <= ra >> 1;
          end else if (!rb[0]) begin
            rb <= rb >> 1;
          end else if (ra == rb) begin
            ra <= ra;
          end else if (ra > rb) begin
            // Both odd, so the difference is even and the shift is exact
            ra <= (ra - rb) >> 1;
          end else begin
            rb <= (rb - ra) >> 1;
          end
        end
        S_FIXUP: begin
          cnt <= sat_inc(cnt);
          // k never exceeds W-1, so the shifted value always fits
          res <= ra << k;
        end
        default: begin
          ra <= ra;
        end
      endcase
    end
  end

  // Output holding register: loads one cycle after DONE entry, clears on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      o         <= '0;
      cycles    <= '0;
    end else if (state == S_DONE) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        o         <= res;
        cycles    <= cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gcd_stream.sv
// tb_gcd_stream: directed and random jobs for gcd_stream, checked against a
// Euclid-based reference GCD and measured handshake timing.
module tb_gcd_stream;

  localparam int BYTES = 2;
  localparam int CW    = 8;
  localparam int W     = 8 * BYTES;
  localparam int MAXLAT = 2 * W + 3;
  localparam int LIMIT  = 200;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  o;
  logic [CW-1:0] cycles;

  int total = 0;
  int bad   = 0;

  gcd_stream #(.BYTES(BYTES), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .cycles    (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
    int unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after an accept edge; counts edges until out_valid is seen
  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < LIMIT) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic recover();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs one full job; entered and left #1 after a clock edge
  task automatic run_job(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int exp_lat, input string tag);
    int n;
    int unsigned exp;
    exp = ref_gcd(32'(ta), 32'(tb_v));
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    wait_out(n);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
    if (out_valid !== 1'b1) begin
      recover();
    end else begin
      chk({tag, " o"}, 32'(o), exp);
      chk({tag, " cycles"}, 32'(cycles), 32'(n));
      chk({tag, " lat_bound"}, 32'(n <= MAXLAT), 32'd1);
      if (exp_lat >= 0) begin
        chk({tag, " latency"}, 32'(n), 32'(exp_lat));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, " drop"}, 32'(out_valid), 32'd0);
      chk({tag, " idle"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int n;
    int s;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset o", 32'(o), 32'd0);
    chk("reset cycles", 32'(cycles), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);

    // Directed functional cases
    run_job(16'd1, 16'd1, 4, "one_one");
    run_job(16'd48, 16'd18, -1, "g48_18");
    run_job(16'd18, 16'd48, -1, "g18_48");
    run_job(16'd0, 16'd35, 1, "zero_a");
    run_job(16'd35, 16'd0, 1, "zero_b");
    run_job(16'd0, 16'd0, 1, "zero_both");
    run_job(16'hFFFF, 16'hFFFF, -1, "all_ones");
    run_job(16'h8000, 16'h4000, -1, "pow2_fixup");
    run_job(16'h8000, 16'h8000, -1, "k15");
    run_job(16'd65521, 16'd65519, -1, "primes");

    // Backpressure: result held, new requests ignored
    a = 16'd48;
    b = 16'd18;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(n);
    chk("bp out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      a = 16'd5;
      b = 16'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp hold valid", 32'(out_valid), 32'd1);
      chk("bp hold o", 32'(o), 32'd6);
      chk("bp hold cycles", 32'(cycles), 32'(n));
      chk("bp in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp release valid", 32'(out_valid), 32'd0);
    chk("bp release ready", 32'(in_ready), 32'd1);
    chk("bp o kept", 32'(o), 32'd6);

    // Reset in the middle of a job
    a = 16'd40000;
    b = 16'd30000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst o", 32'(o), 32'd0);
    chk("midrst cycles", 32'(cycles), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("midrst no pulse", 32'(out_valid), 32'd0);
    end
    run_job(16'd21, 16'd14, -1, "after_rst");

    // Random pairs against the reference GCD
    for (int i = 0; i < 2000; i++) begin
      ra = W'($urandom) >> $urandom_range(0, 15);
      rb = W'($urandom) >> $urandom_range(0, 15);
      s = $urandom_range(0, 6);
      ra = ra << s;
      rb = rb << s;
      if ($urandom_range(0, 31) == 0) ra = '0;
      if ($urandom_range(0, 31) == 0) rb = '0;
      run_job(ra, rb, (ra == '0 || rb == '0) ? 1 : -1, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
